// File: rtl/disp_cmd_writer.sv
// Paced writer into an external async display-command FIFO (nWR strobe, nFF flag).
// Optional sticky full-wait timeout flag: define DISP_CMD_WR_TIMEOUT_EN.
module disp_cmd_writer #(
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       nff_in,
    output logic [7:0] fifo_data,
    output logic       fifo_nwr,
    output logic       busy,
    output logic       full_timeout
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       nwr_q, nwr_d;
    logic       nff_meta_q, nff_s_q;
    logic       accept;

    assign cmd_ready = (state_q == IDLE) && nff_s_q && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign fifo_data = data_q;
    assign fifo_nwr  = nwr_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        nwr_d   = nwr_q;
        case (state_q)
            IDLE: begin
                nwr_d = 1'b1;
                if (accept) begin
                    data_d  = cmd_data;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Expired setup parks here while the FIFO reads full
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (nff_s_q) begin
                    nwr_d   = 1'b0;
                    cnt_d   = PULSE_LD;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    nwr_d   = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                nwr_d   = 1'b1;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            data_q     <= 8'h00;
            nwr_q      <= 1'b1;
            nff_meta_q <= 1'b0;
            nff_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            nwr_q      <= nwr_d;
            nff_meta_q <= nff_in;
            nff_s_q    <= nff_meta_q;
        end
    end

`ifdef DISP_CMD_WR_TIMEOUT_EN
    logic        full_wait;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_flag_q, tmo_flag_d;

    assign full_wait = (state_q == SETUP) && (cnt_q == 8'd0) && !nff_s_q;

    always_comb begin
        tmo_cnt_d  = 16'd0;
        tmo_flag_d = tmo_flag_q;
        if (full_wait) begin
            tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
            if (tmo_cnt_d >= TIMEOUT_CYCLES) begin
                tmo_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q  <= 16'd0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign full_timeout = tmo_flag_q;
`else
    logic unused_tmo;
    assign unused_tmo   = ^TIMEOUT_CYCLES;
    assign full_timeout = 1'b0;
`endif

endmodule
